serial_adder_host: RTL and testbench

SERIAL_ADDER_HOST -- requirements
Module: serial_adder_host

---
 rtl/serial_adder_host.sv | 126 ++++++++++++
 tb/tb_serial_adder_host.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_host.sv
// Host controller for a bit-serial adder: feeds two operands LSB first, collects the
// serial sum and presents it as a parallel result with carry out.
module serial_adder_host #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ZLAT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             x,
  output logic             y,
  input  logic             z,
  output logic             add_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, FLUSH, DONE_ST} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   sa, sa_n, sb, sb_n, res, res_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            x_n, y_n, clr_n, busy_n, done_n, cout_n, cap;
  logic [WIDTH-1:0] sum_n;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      res     <= '0;
      cnt     <= '0;
      x       <= 1'b0;
      y       <= 1'b0;
      add_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state   <= state_n;
      sa      <= sa_n;
      sb      <= sb_n;
      res     <= res_n;
      cnt     <= cnt_n;
      x       <= x_n;
      y       <= y_n;
      add_clr <= clr_n;
      busy    <= busy_n;
      done    <= done_n;
      sum     <= sum_n;
      cout    <= cout_n;
    end
  end

  // Next state; x/y are loaded one edge ahead so they line up with the SHIFT cycles
  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    res_n   = res;
    cnt_n   = cnt;
    x_n     = 1'b0;
    y_n     = 1'b0;
    cap     = 1'b0;
    sum_n   = sum;
    cout_n  = cout;

    case (state)
      IDLE: begin
        if (start) begin
          sa_n    = {1'b0, a};
          sb_n    = {1'b0, b};
          res_n   = '0;
          cnt_n   = '0;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        x_n     = sa[0];
        y_n     = sb[0];
        sa_n    = sa >> 1;
        sb_n    = sb >> 1;
        state_n = SHIFT;
      end
      SHIFT: begin
        // with a registered adder the first Z after CLEAR is stale
        cap   = (ZLAT == 0) || (cnt != '0);
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH)) begin
          state_n = (ZLAT == 0) ? DONE_ST : FLUSH;
        end else begin
          x_n  = sa[0];
          y_n  = sb[0];
          sa_n = sa >> 1;
          sb_n = sb >> 1;
        end
      end
      FLUSH: begin
        cap     = 1'b1;
        state_n = DONE_ST;
      end
      DONE_ST: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (cap) res_n = {z, res[SW-1:1]};

    clr_n  = (state_n == CLEAR);
    busy_n = (state_n == CLEAR) || (state_n == SHIFT) || (state_n == FLUSH);
    done_n = (state_n == DONE_ST);
    if (state_n == DONE_ST) begin
      sum_n  = res_n[WIDTH-1:0];
      cout_n = res_n[WIDTH];
    end
  end

endmodule

// File: tb/tb_serial_adder_host.sv
// Bench for serial_adder_host: two instances (ZLAT=0 with a combinational adder model,
// ZLAT=1 with a registered adder model), table-driven operations and a result scoreboard.
module tb_serial_adder_host;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a, b;
  bit         sel;

  logic       start0, x0, y0, z0, clr0, busy0, done0, cout0;
  logic [7:0] sum0;
  logic       start1, x1, y1, z1, clr1, busy1, done1, cout1;
  logic [7:0] sum1;
  logic       c0 = 1'b1;
  logic       c1 = 1'b1;

  logic       mx, my, mclr, mbusy, mdone, mcout;
  logic [7:0] msum;

  int total = 0;
  int bad   = 0;
  logic [8:0] q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    bit         b2b;
  } vec_t;
  vec_t tbl[9];

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  serial_adder_host #(.WIDTH(8), .ZLAT(0)) u0 (
    .clk(clk), .reset(reset), .start(start0), .a(a), .b(b),
    .x(x0), .y(y0), .z(z0), .add_clr(clr0), .busy(busy0), .done(done0),
    .sum(sum0), .cout(cout0));

  serial_adder_host #(.WIDTH(8), .ZLAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .a(a), .b(b),
    .x(x1), .y(y1), .z(z1), .add_clr(clr1), .busy(busy1), .done(done1),
    .sum(sum1), .cout(cout1));

  // Serial adder models: combinational sum for u0, registered sum for u1
  assign z0 = x0 ^ y0 ^ c0;
  always @(posedge clk) begin
    c0 <= clr0 ? 1'b0 : ((x0 & y0) | (x0 & c0) | (y0 & c0));
    z1 <= x1 ^ y1 ^ c1;
    c1 <= clr1 ? 1'b0 : ((x1 & y1) | (x1 & c1) | (y1 & c1));
  end

  assign mx    = sel ? x1    : x0;
  assign my    = sel ? y1    : y0;
  assign mclr  = sel ? clr1  : clr0;
  assign mbusy = sel ? busy1 : busy0;
  assign mdone = sel ? done1 : done0;
  assign msum  = sel ? sum1  : sum0;
  assign mcout = sel ? cout1 : cout0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: pop the expected result whenever a DONE pulse appears
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset && (done0 || done1)) begin
      if (q.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(msum), 32'(e[7:0]));
        chk("cout", 32'(mcout), 32'(e[8]));
        chk("busy_in_done", 32'(mbusy), 32'd0);
      end
    end
    if (reset && !mbusy) chk("xy_idle", 32'({mx, my}), 32'd0);
  end

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] es,
                        input logic ec, input int exp_lat, input int exp_acc,
                        input int gl_at, input logic [7:0] ga, input logic [7:0] gb,
                        input int rst_at);
    int acc;
    int n;
    int clr_cnt;
    bit aborted;
    logic [8:0] xs, ys;
    @(negedge clk);
    a = ta;
    b = tb_;
    start = 1'b1;
    q.push_back({ec, es});
    acc = 0;
    do begin
      @(posedge clk); #1;
      acc++;
    end while (!mbusy && acc < 20);
    start = 1'b0;
    chk("accept_edges", 32'(acc), 32'(exp_acc));
    chk("clear_cycle", 32'({mclr, mx, my}), 32'b100);
    clr_cnt = 1;
    xs = '0;
    ys = '0;
    n = 0;
    aborted = 1'b0;
    while (!mdone && n < 40 && !aborted) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n <= 9) begin
        xs[n-1] = mx;
        ys[n-1] = my;
      end
      if (mclr) clr_cnt++;
      if (n == gl_at) begin
        a = ga;
        b = gb;
        start = 1'b1;
      end
      if (n == rst_at) begin
        reset = 1'b0;
        #1;
        chk("reset_outputs", 32'({msum, mcout, mx, my, mclr, mbusy, mdone}), 32'd0);
        void'(q.pop_back());
        aborted = 1'b1;
      end
    end
    if (aborted) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("done_in_reset", 32'(mdone), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
    end else begin
      chk("latency", 32'(n), 32'(exp_lat));
      chk("add_clr_count", 32'(clr_cnt), 32'd1);
      chk("x_seq", 32'(xs), 32'({1'b0, ta}));
      chk("y_seq", 32'(ys), 32'({1'b0, tb_}));
    end
  endtask

  initial begin
    tbl[0] = '{8'h05, 8'h00, 8'h05, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
    tbl[3] = '{8'h0F, 8'h01, 8'h10, 1'b0, 1'b1};
    tbl[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b1};
    tbl[5] = '{8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[8] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};

    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    sel = 1'b0;
    @(posedge clk); #1;
    chk("rst_u0", 32'({sum0, cout0, x0, y0, clr0, busy0, done0}), 32'd0);
    chk("rst_u1", 32'({sum1, cout1, x1, y1, clr1, busy1, done1}), 32'd0);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("start_in_reset", 32'({busy0, busy1}), 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (!tbl[i].b2b) repeat (2) @(posedge clk);
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, 10, tbl[i].b2b ? 2 : 1,
             0, 8'h00, 8'h00, 0);
    end

    // START pulsed mid-SHIFT with other operands must be ignored
    repeat (2) @(posedge clk);
    run_op(8'h33, 8'h44, 8'h77, 1'b0, 10, 1, 3, 8'hAA, 8'h77, 0);

    // Reset in the 4th SHIFT cycle aborts, then a clean operation
    repeat (2) @(posedge clk);
    run_op(8'hC3, 8'h5A, 8'h1D, 1'b1, 10, 1, 0, 8'h00, 8'h00, 4);
    run_op(8'h12, 8'h34, 8'h46, 1'b0, 10, 1, 0, 8'h00, 8'h00, 0);

    // Registered-adder instance
    repeat (2) @(posedge clk);
    sel = 1'b1;
    repeat (2) @(posedge clk);
    run_op(8'h80, 8'h80, 8'h00, 1'b1, 11, 1, 0, 8'h00, 8'h00, 0);
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, 11, 2, 0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clk);
    run_op(8'h5A, 8'hA5, 8'hFF, 1'b0, 11, 1, 0, 8'h00, 8'h00, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("sum_hold", 32'({cout1, sum1}), 32'h0FF);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
